nonce_scanner: RTL and testbench
================================

// Module: nonce_scanner
// PURPOSE
//  Initiator side of the double-SHA256 hasher handshake: loads an 80-byte header template, target and nonce range.
//  Drives one hash request per nonce, checks each digest against the target and reports the first winning nonce.
//  Sits between the host byte-load interface and the sha256 core.
// PARAMETERS
//  STOP_ON_FIND  1  1: halt in S_FOUND on first hit; 0: pulse found and keep scanning
//  ZBITS_W       8  width of the target leading-zero count
// PORTS
//  clk           in   1    sole clock, rising edge
//  rst           in   1    synchronous, active-high reset
//  cfg_valid     in   1    load byte valid
//  cfg_data      in   8    load byte (header[0..75], nonce_lo LE[4], nonce_hi LE[4], zbits[1]; 85 total)
//  cfg_ready     out  1    high only in S_LOAD
//  go            in   1    start scan (accepted in S_ARMED only)
//  abort         in   1    stop scan, return to S_ARMED keeping config
//  hs_start      out  1    one-cycle hash request
//  hs_block      out  640  {header[0..75], nonce byte-swapped LE}; stable from hs_start to hs_done
//  hs_done       in   1    one-cycle completion pulse from hasher
//  hs_hash       in   256  digest, valid when hs_done=1
//  busy          out  1    high in S_START/S_WAIT/S_CHECK
//  found         out  1    one-cycle pulse per winning nonce
//  found_nonce   out  32   last winning nonce, held
//  exhausted     out  1    level: range finished without stop
// BEHAVIOUR
//  Reset: state=S_LOAD, byte count=0, all outputs 0 except cfg_ready=1; found_nonce=0.
//  S_LOAD: byte accepted when cfg_valid&cfg_ready; after byte 85 -> S_ARMED. Bytes are never dropped or reordered.
//  S_ARMED: go -> S_START with nonce=nonce_lo and exhausted cleared. cfg_valid here restarts the load at byte 0 -> S_LOAD.
//  S_START: hs_start=1 for exactly one cycle -> S_WAIT.
//  S_WAIT: wait indefinitely; hs_done outside S_WAIT is ignored. On hs_done, register hs_hash -> S_CHECK.
//  S_CHECK (one cycle): V=byte-reverse(hash). Hit when the top zbits bits of V are 0 (zbits=0 always hits).
//   Hit: found pulse and found_nonce<=nonce, same cycle.
//   Hit and STOP_ON_FIND=1 -> S_FOUND.
//   Otherwise, nonce==nonce_hi -> exhausted=1, S_ARMED.
//   Otherwise nonce<=nonce+1 -> S_START.
//  Nonce increment wraps 0xFFFFFFFF->0. Termination is by equality with nonce_hi only, so lo>hi scans through the wrap.
//  S_FOUND: hold; go resumes at nonce+1 (or sets exhausted if nonce==nonce_hi). cfg_valid -> S_LOAD.
//  abort: wins over every event in S_START/S_WAIT/S_CHECK. Goes to S_ARMED next cycle with no found pulse.
//   A hash already in flight is still awaited internally: S_ARMED ignores go until its hs_done arrives (drain flag).
//  Per-nonce latency: 1 (start) + hasher latency + 1 (check) cycles.
//  rst mid-operation: immediate return to reset state; config is lost.
// CONFIGURATION
//  HASH_COUNT_EN defined: adds output hash_count[31:0]. It increments on each S_CHECK, clears on go from S_ARMED,
//   and saturates at 0xFFFFFFFF.
//  HASH_COUNT_EN undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Package btc_pkg: HDR_BYTES=76, LOAD_BYTES=85, state encoding, bswap32 and bswap256 functions.
//  Sub-module target_cmp: combinational, (digest, zbits) -> hit. Reused by any later share-difficulty checker.
// TESTING
//  Load Bitcoin genesis header, zbits=32, lo=hi=0x7C2BAC1D -> single hs_start, found pulse, found_nonce=0x7C2BAC1D.
//  Same header, lo=0x7C2BAC1A, hi=0x7C2BAC1F, stub hasher returns hit only for ..1D -> exactly 4 hs_start, found at 4th.
//  lo=0xFFFFFFFE, hi=0x00000001, never-hit stub -> nonces FE,FF,00,01 issued, then exhausted=1.
//  abort in S_WAIT -> S_ARMED next cycle; go before stub hs_done is ignored; go after hs_done restarts at lo.
//  STOP_ON_FIND=0, stub hits on every even nonce, lo=0, hi=5 -> found pulses for 0,2,4; exhausted=1.
//  rst during S_WAIT -> cfg_ready=1, busy=0, found_nonce=0; a late hs_done produces no activity.

Source files
------------

// File: rtl/btc_pkg.sv
// -----------------------------------------------------------------------------
// btc_pkg
// Shared constants and helpers for the Bitcoin nonce scanning datapath.
//   HDR_BYTES  : header template bytes that precede the nonce (76)
//   LOAD_BYTES : bytes in one configuration load (76 + 4 + 4 + 1 = 85)
//   S_*        : scanner FSM state encoding
//   bswap32    : reverse the byte order of a 32-bit word
//   bswap256   : reverse the byte order of a 256-bit digest
// -----------------------------------------------------------------------------
package btc_pkg;

    localparam int HDR_BYTES  = 76;
    localparam int LOAD_BYTES = 85;

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_FOUND = 3'd5;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [255:0] bswap256(input logic [255:0] w);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            r[8*k +: 8] = w[255-8*k -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/target_cmp.sv
// -----------------------------------------------------------------------------
// target_cmp
// Combinational difficulty check: a raw SHA256d digest meets the target when
// the top i_zbits bits of its byte-reversed (big-number) value are all zero.
// A zero-bit target always hits.
//   i_digest : raw digest as produced by the hasher
//   i_zbits  : required count of leading zero bits
//   o_hit    : digest meets the target
// -----------------------------------------------------------------------------
module target_cmp
    import btc_pkg::*;
#(
    parameter int ZBITS_W = 8
) (
    input  logic [255:0]         i_digest,
    input  logic [ZBITS_W-1:0]   i_zbits,
    output logic                 o_hit
);

    logic [255:0] w_value;
    logic [255:0] w_mask;

    assign w_value = bswap256(i_digest);
    // Ones in the top i_zbits positions; all zero when i_zbits is 0.
    assign w_mask  = ~({256{1'b1}} >> i_zbits);
    assign o_hit   = ((w_value & w_mask) == '0);

endmodule

// File: rtl/nonce_scanner.sv
// -----------------------------------------------------------------------------
// nonce_scanner
// Initiator side of the double-SHA256 hasher handshake. A host streams in an
// 85-byte configuration (76 header bytes, nonce_lo LE, nonce_hi LE, zbits);
// on go the scanner issues one hash request per nonce from nonce_lo up to and
// including nonce_hi (wrapping through 0xFFFFFFFF), checks each digest against
// the leading-zero target and reports winning nonces.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   cfg_valid/data/ready : configuration byte stream (ready only in S_LOAD)
//   go, abort            : start scan / stop scan keeping configuration
//   hs_start, hs_block   : hash request pulse and 640-bit block to hash
//   hs_done, hs_hash     : hasher completion pulse and digest
//   busy                 : a scan step is in progress
//   found, found_nonce   : winning-nonce pulse and last winning nonce
//   exhausted            : range finished without stopping on a hit
//   hash_count           : digests checked since go (HASH_COUNT_EN only)
//
// Build option: define HASH_COUNT_EN to add the saturating hash_count output.
// -----------------------------------------------------------------------------
module nonce_scanner
    import btc_pkg::*;
#(
    parameter int STOP_ON_FIND = 1,
    parameter int ZBITS_W      = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    input  logic [7:0]     cfg_data,
    output logic           cfg_ready,
    input  logic           go,
    input  logic           abort,
    output logic           hs_start,
    output logic [639:0]   hs_block,
    input  logic           hs_done,
    input  logic [255:0]   hs_hash,
    output logic           busy,
    output logic           found,
    output logic [31:0]    found_nonce,
`ifdef HASH_COUNT_EN
    output logic [31:0]    hash_count,
`endif
    output logic           exhausted
);

    logic [2:0]          r_state;
    logic [6:0]          r_cnt;
    logic [607:0]        r_hdr;
    logic [31:0]         r_lo;
    logic [31:0]         r_hi;
    logic [ZBITS_W-1:0]  r_zbits;
    logic [31:0]         r_nonce;
    logic [255:0]        r_hash;
    logic                r_pend;
    logic                r_found;
    logic [31:0]         r_found_nonce;
    logic                r_exh;
`ifdef HASH_COUNT_EN
    logic [31:0]         r_hcnt;
`endif

    logic                w_hit;
    logic                w_last;

    target_cmp #(.ZBITS_W(ZBITS_W)) u_cmp (
        .i_digest (r_hash),
        .i_zbits  (r_zbits),
        .o_hit    (w_hit)
    );

    assign w_last      = (r_nonce == r_hi);
    assign cfg_ready   = (r_state == S_LOAD);
    // abort in S_START suppresses the request so nothing is left in flight.
    assign hs_start    = (r_state == S_START) && !abort;
    assign hs_block    = {r_hdr, bswap32(r_nonce)};
    assign busy        = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_CHECK);
    assign found       = r_found;
    assign found_nonce = r_found_nonce;
    assign exhausted   = r_exh;
`ifdef HASH_COUNT_EN
    assign hash_count  = r_hcnt;
`endif

    always_ff @(posedge clk) begin
        r_found <= 1'b0;
        if (rst) begin
            r_state       <= S_LOAD;
            r_cnt         <= '0;
            r_hdr         <= '0;
            r_nonce       <= '0;
            r_pend        <= 1'b0;
            r_found_nonce <= '0;
            r_exh         <= 1'b0;
`ifdef HASH_COUNT_EN
            r_hcnt        <= '0;
`endif
        end else begin
            // Tracks a request whose hs_done has not yet come back, even
            // after an abort has moved the FSM on.
            if (hs_start) begin
                r_pend <= 1'b1;
            end else if (hs_done) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                S_LOAD: begin
                    if (cfg_valid) begin
                        if (r_cnt < 7'(HDR_BYTES)) begin
                            r_hdr <= {r_hdr[599:0], cfg_data};
                        end else if (r_cnt < 7'(HDR_BYTES + 4)) begin
                            r_lo <= {cfg_data, r_lo[31:8]};
                        end else if (r_cnt < 7'(HDR_BYTES + 8)) begin
                            r_hi <= {cfg_data, r_hi[31:8]};
                        end else begin
                            r_zbits <= ZBITS_W'(cfg_data);
                        end
                        if (r_cnt == 7'(LOAD_BYTES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_ARMED;
                        end else begin
                            r_cnt <= r_cnt + 7'd1;
                        end
                    end
                end
                S_ARMED: begin
                    if (cfg_valid) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end else if (go && !r_pend) begin
                        r_nonce <= r_lo;
                        r_exh   <= 1'b0;
`ifdef HASH_COUNT_EN
                        r_hcnt  <= '0;
`endif
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_state <= abort ? S_ARMED : S_WAIT;
                end
                S_WAIT: begin
                    if (abort) begin
                        r_state <= S_ARMED;
                    end else if (hs_done) begin
                        r_hash  <= hs_hash;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        r_state <= S_ARMED;
                    end else begin
`ifdef HASH_COUNT_EN
                        if (r_hcnt != 32'hFFFF_FFFF) begin
                            r_hcnt <= r_hcnt + 32'd1;
                        end
`endif
                        if (w_hit) begin
                            r_found       <= 1'b1;
                            r_found_nonce <= r_nonce;
                        end
                        if (w_hit && (STOP_ON_FIND != 0)) begin
                            r_state <= S_FOUND;
                        end else if (w_last) begin
                            r_exh   <= 1'b1;
                            r_state <= S_ARMED;
                        end else begin
                            r_nonce <= r_nonce + 32'd1;
                            r_state <= S_START;
                        end
                    end
                end
                S_FOUND: begin
                    if (cfg_valid) begin
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
                    end else if (go) begin
                        if (w_last) begin
                            r_exh   <= 1'b1;
                            r_state <= S_ARMED;
                        end else begin
                            r_nonce <= r_nonce + 32'd1;
                            r_state <= S_START;
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_scanner.sv
// -----------------------------------------------------------------------------
// tb_nonce_scanner
// Two scanner instances (stop-on-find and keep-scanning) with stub hashers
// whose digests hit or miss depending on the nonce. Expected nonces and
// winning nonces are queued ahead of each scan and checked as they appear.
// -----------------------------------------------------------------------------
module tb_nonce_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [7:0]     cfg_data;
    logic           cfg_valid1, cfg_valid0;
    logic           cfg_ready1, cfg_ready0;
    logic           go1, go0, abort1, abort0;
    logic           hs_start1, hs_start0;
    logic [639:0]   hs_block1, hs_block0;
    logic           hs_done1, hs_done0;
    logic [255:0]   hs_hash1, hs_hash0;
    logic           busy1, busy0;
    logic           found1, found0;
    logic [31:0]    found_nonce1, found_nonce0;
    logic           exhausted1, exhausted0;

    nonce_scanner #(.STOP_ON_FIND(1), .ZBITS_W(8)) dut1 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid1), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready1), .go(go1), .abort(abort1), .hs_start(hs_start1),
        .hs_block(hs_block1), .hs_done(hs_done1), .hs_hash(hs_hash1),
        .busy(busy1), .found(found1), .found_nonce(found_nonce1),
        .exhausted(exhausted1)
    );

    nonce_scanner #(.STOP_ON_FIND(0), .ZBITS_W(8)) dut0 (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid0), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready0), .go(go0), .abort(abort0), .hs_start(hs_start0),
        .hs_block(hs_block0), .hs_done(hs_done0), .hs_hash(hs_hash0),
        .busy(busy0), .found(found0), .found_nonce(found_nonce0),
        .exhausted(exhausted0)
    );

    // Bitcoin genesis block header without its nonce.
    logic [607:0] GEN = 608'h01000000_0000000000000000000000000000000000000000000000000000000000000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;   // 0 never-style, 1 only 0x7C2BAC1D, 2 even nonces
    int lat     = 3;
    int starts1 = 0, starts0 = 0, founds1 = 0, founds0 = 0;
    logic [31:0] q_n1[$], q_n0[$], q_f1[$], q_f0[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [255:0] rev256(input logic [255:0] v);
        logic [255:0] r;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = v[255-8*k -: 8];
        return r;
    endfunction

    // Hit digest: big-number value has 32+ leading zeros. Miss digest: top word
    // is 0x00000001, so it fails a 32-bit target but passes a 31-bit one.
    function automatic logic [255:0] mkhash(input logic [31:0] n);
        logic hit;
        logic [255:0] v;
        case (mode)
            1: hit = (n == 32'h7C2BAC1D);
            2: hit = (n[0] == 1'b0);
            default: hit = 1'b0;
        endcase
        v = hit ? {32'h0, 192'h0, n} : {32'h00000001, 192'h0, n};
        return rev256(v);
    endfunction

    // Stub hashers: respond lat cycles after each request.
    int c1 = 0, c0 = 0;
    logic [31:0] n1, n0;
    always @(posedge clk) begin
        hs_done1 <= 1'b0;
        if (hs_start1) begin
            c1 <= lat;
            n1 <= rev32(hs_block1[31:0]);
        end else if (c1 != 0) begin
            c1 <= c1 - 1;
            if (c1 == 1) begin
                hs_done1 <= 1'b1;
                hs_hash1 <= mkhash(n1);
            end
        end
    end
    always @(posedge clk) begin
        hs_done0 <= 1'b0;
        if (hs_start0) begin
            c0 <= lat;
            n0 <= rev32(hs_block0[31:0]);
        end else if (c0 != 0) begin
            c0 <= c0 - 1;
            if (c0 == 1) begin
                hs_done0 <= 1'b1;
                hs_hash0 <= mkhash(n0);
            end
        end
    end

    // Scoreboard monitors.
    always @(negedge clk) begin
        if (hs_start1) begin
            starts1++;
            chk("dut1 header", 64'(hs_block1[639:32] == GEN), 64'd1);
            if (q_n1.size() == 0) chk("dut1 unexpected start", 64'(rev32(hs_block1[31:0])), 64'hDEAD);
            else chk("dut1 start nonce", 64'(rev32(hs_block1[31:0])), 64'(q_n1.pop_front()));
        end
        if (found1) begin
            founds1++;
            if (q_f1.size() == 0) chk("dut1 unexpected found", 64'(found_nonce1), 64'hDEAD);
            else chk("dut1 found nonce", 64'(found_nonce1), 64'(q_f1.pop_front()));
        end
        if (hs_start0) begin
            starts0++;
            chk("dut0 header", 64'(hs_block0[639:32] == GEN), 64'd1);
            if (q_n0.size() == 0) chk("dut0 unexpected start", 64'(rev32(hs_block0[31:0])), 64'hDEAD);
            else chk("dut0 start nonce", 64'(rev32(hs_block0[31:0])), 64'(q_n0.pop_front()));
        end
        if (found0) begin
            founds0++;
            if (q_f0.size() == 0) chk("dut0 unexpected found", 64'(found_nonce0), 64'hDEAD);
            else chk("dut0 found nonce", 64'(found_nonce0), 64'(q_f0.pop_front()));
        end
    end

    task automatic load_cfg(input int sel, input logic [31:0] lo, input logic [31:0] hi, input logic [7:0] z);
        logic [7:0] b[85];
        int i, guard;
        for (int k = 0; k < 76; k++) b[k] = GEN[607-8*k -: 8];
        for (int k = 0; k < 4; k++) begin
            b[76+k] = lo[8*k +: 8];
            b[80+k] = hi[8*k +: 8];
        end
        b[84] = z;
        i = 0;
        guard = 0;
        while (i < 85 && guard < 400) begin
            @(negedge clk);
            cfg_data = b[i];
            if (sel == 1) cfg_valid1 = 1'b1; else cfg_valid0 = 1'b1;
            if ((sel == 1) ? cfg_ready1 : cfg_ready0) i++;
            guard++;
        end
        @(negedge clk);
        cfg_valid1 = 1'b0;
        cfg_valid0 = 1'b0;
        if (i < 85) chk("load timeout", 64'(i), 64'd85);
    endtask

    task automatic pulse_go(input int sel);
        @(negedge clk);
        if (sel == 1) go1 = 1'b1; else go0 = 1'b1;
        @(negedge clk);
        go1 = 1'b0;
        go0 = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int k;
        k = 0;
        while (((sel == 1) ? busy1 : busy0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) chk("scan timeout", 64'(k), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [7:0]  z;
        int          md;
        int          n_start;
        int          n_found;
        logic [31:0] fnonce;
        logic        exh;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int s0, f0;
        logic [31:0] n;

        tbl[0] = '{32'h7C2BAC1D, 32'h7C2BAC1D, 8'd32, 1, 1, 1, 32'h7C2BAC1D, 1'b0};
        tbl[1] = '{32'h7C2BAC1A, 32'h7C2BAC1F, 8'd32, 1, 4, 1, 32'h7C2BAC1D, 1'b0};
        tbl[2] = '{32'hFFFFFFFE, 32'h00000001, 8'd32, 0, 4, 0, 32'h7C2BAC1D, 1'b1};
        tbl[3] = '{32'h00000005, 32'h00000009, 8'd0,  0, 1, 1, 32'h00000005, 1'b0};
        tbl[4] = '{32'h00000003, 32'h00000003, 8'd31, 0, 1, 1, 32'h00000003, 1'b0};

        rst = 1'b1; cfg_valid1 = 0; cfg_valid0 = 0; cfg_data = 0;
        go1 = 0; go0 = 0; abort1 = 0; abort0 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset cfg_ready", 64'(cfg_ready1), 64'd1);
        chk("reset busy", 64'(busy1), 64'd0);
        chk("reset found", 64'(found1), 64'd0);
        chk("reset found_nonce", 64'(found_nonce1), 64'd0);
        chk("reset exhausted", 64'(exhausted1), 64'd0);
        chk("reset hs_start", 64'(hs_start1), 64'd0);
        chk("reset hs_block", 64'(hs_block1 == '0), 64'd1);

        for (int r = 0; r < 5; r++) begin
            mode = tbl[r].md;
            lat  = 3;
            load_cfg(1, tbl[r].lo, tbl[r].hi, tbl[r].z);
            chk("armed cfg_ready", 64'(cfg_ready1), 64'd0);
            n = tbl[r].lo;
            for (int k = 0; k < tbl[r].n_start; k++) begin
                q_n1.push_back(n);
                n = n + 32'd1;
            end
            if (tbl[r].n_found != 0) q_f1.push_back(tbl[r].fnonce);
            s0 = starts1; f0 = founds1;
            pulse_go(1);
            wait_idle(1);
            chk($sformatf("row%0d starts", r), 64'(starts1 - s0), 64'(tbl[r].n_start));
            chk($sformatf("row%0d founds", r), 64'(founds1 - f0), 64'(tbl[r].n_found));
            chk($sformatf("row%0d found_nonce", r), 64'(found_nonce1), 64'(tbl[r].fnonce));
            chk($sformatf("row%0d exhausted", r), 64'(exhausted1), 64'(tbl[r].exh));
            chk($sformatf("row%0d queue", r), 64'(q_n1.size() + q_f1.size()), 64'd0);
        end

        // Abort while waiting on the hasher; go is ignored until the drain.
        mode = 0; lat = 20;
        load_cfg(1, 32'd10, 32'd20, 8'd32);
        q_n1.push_back(32'd10);
        s0 = starts1; f0 = founds1;
        pulse_go(1);
        repeat (3) @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort to armed", 64'(busy1), 64'd0);
        chk("abort cfg_ready", 64'(cfg_ready1), 64'd0);
        pulse_go(1);
        repeat (2) @(negedge clk);
        chk("go during drain ignored", 64'(busy1), 64'd0);
        chk("no start during drain", 64'(starts1 - s0), 64'd1);
        begin
            int k;
            k = 0;
            while (!hs_done1 && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (k >= 100) chk("drain timeout", 64'(k), 64'd0);
        end
        lat = 2;
        for (int v = 10; v <= 20; v++) q_n1.push_back(32'(v));
        pulse_go(1);
        wait_idle(1);
        chk("post-abort starts", 64'(starts1 - s0), 64'd12);
        chk("post-abort exhausted", 64'(exhausted1), 64'd1);
        chk("post-abort no found", 64'(founds1 - f0), 64'd0);
        chk("post-abort queue", 64'(q_n1.size()), 64'd0);

        // Keep-scanning instance: hits on even nonces.
        mode = 2; lat = 3;
        load_cfg(0, 32'd0, 32'd5, 8'd32);
        for (int v = 0; v <= 5; v++) q_n0.push_back(32'(v));
        q_f0.push_back(32'd0); q_f0.push_back(32'd2); q_f0.push_back(32'd4);
        pulse_go(0);
        wait_idle(0);
        chk("nostop starts", 64'(starts0), 64'd6);
        chk("nostop founds", 64'(founds0), 64'd3);
        chk("nostop found_nonce", 64'(found_nonce0), 64'd4);
        chk("nostop exhausted", 64'(exhausted0), 64'd1);
        chk("nostop queue", 64'(q_n0.size() + q_f0.size()), 64'd0);

        // Reset while a hash is in flight.
        mode = 0; lat = 20;
        load_cfg(1, 32'd100, 32'd200, 8'd32);
        q_n1.push_back(32'd100);
        pulse_go(1);
        repeat (3) @(negedge clk);
        chk("pre-reset busy", 64'(busy1), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst cfg_ready", 64'(cfg_ready1), 64'd1);
        chk("rst busy", 64'(busy1), 64'd0);
        chk("rst found_nonce", 64'(found_nonce1), 64'd0);
        chk("rst exhausted", 64'(exhausted1), 64'd0);
        s0 = starts1; f0 = founds1;
        repeat (30) @(negedge clk);
        chk("late done no start", 64'(starts1 - s0), 64'd0);
        chk("late done no found", 64'(founds1 - f0), 64'd0);
        chk("late done idle", 64'(busy1), 64'd0);
        chk("late done cfg_ready", 64'(cfg_ready1), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
